// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix-multiply MAC engine:
//   - mm_state_e : sequencer state encoding (IDLE, RUN, DRAIN, FINISH)
//   - STAGES     : depth of the issue -> result pipeline
//   - mm_aw()    : operand/result address width for an NxN matrix
//   - mm_accw()  : accumulator width that holds N worst-case products
//   - idx()      : row-major element index r*n + c
// ---------------------------------------------------------------------------
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } mm_state_e;

    // Issue edge (memory samples address) + data edge (MAC retires).
    localparam int STAGES = 2;

    function automatic int mm_aw(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Each product fits in 2*DW bits; summing N of them needs clog2(N) more.
    function automatic int mm_accw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/mm_mac_unit.sv
// ---------------------------------------------------------------------------
// mm_mac_unit
// Second pipeline stage of the MAC engine: multiplies the operand pair that
// arrives from the synchronous-read memories, accumulates over k, and
// registers a finished C element on the last-of-k term.
//
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   i_clr          synchronous clear (controller load): acc, flags, strobe
//   i_vld          operand pair on i_a/i_b is a real issue (not a stall)
//   i_first        first k term: accumulator restarts from the product
//   i_last         last k term: result register loads the new sum
//   i_tag          result address carried from the issue stage
//   i_wr_en        controller write permission, sampled on the last term
//   i_a, i_b       signed operands
//   o_res_we       one-cycle result write strobe
//   o_res_addr     result address
//   o_res_data     sign-extended sum of products
//   o_drop_err     sticky: a result completed while i_wr_en was low
// ---------------------------------------------------------------------------
module mm_mac_unit
    import mm_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int ACCW = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_vld,
    input  logic                   i_first,
    input  logic                   i_last,
    input  logic [AW-1:0]          i_tag,
    input  logic                   i_wr_en,
    input  logic signed [DW-1:0]   i_a,
    input  logic signed [DW-1:0]   i_b,
    output logic                   o_res_we,
    output logic [AW-1:0]          o_res_addr,
    output logic [ACCW-1:0]        o_res_data,
    output logic                   o_drop_err
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_acc_nxt;
    logic signed [ACCW-1:0] r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(ACCW - 2*DW){w_prod[2*DW-1]}}, w_prod};
    // First term restarts the sum so no explicit clear is needed between
    // elements; stalls never assert i_vld, so acc is untouched by them.
    assign w_acc_nxt  = i_first ? w_prod_ext : (r_acc + w_prod_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            o_res_we   <= 1'b0;
            o_res_addr <= '0;
            o_res_data <= '0;
            o_drop_err <= 1'b0;
        end else if (i_clr) begin
            r_acc      <= '0;
            o_res_we   <= 1'b0;
            o_res_addr <= '0;
            o_res_data <= '0;
            o_drop_err <= 1'b0;
        end else begin
            o_res_we <= 1'b0;
            if (i_vld) begin
                r_acc <= w_acc_nxt;
                if (i_last) begin
                    o_res_data <= w_acc_nxt;
                    o_res_addr <= i_tag;
                    o_res_we   <= i_wr_en;
                    if (!i_wr_en) begin
                        o_drop_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mm_mac_engine.sv
// ---------------------------------------------------------------------------
// mm_mac_engine
// Sequencer + datapath computing C = A x B for NxN signed matrices held in
// two synchronous-read operand memories. Walks (i, j, k) in row-major order,
// one operand pair per cycle while start_mac is high, and writes each C
// element to a result memory two cycles after its last k term is issued.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   load              clear counters, accumulator, flags; back to IDLE
//   start_mac         level: run / continue while high, stall while low
//   wr_en             controller write permission (gates res_we)
//   a_addr, b_addr    operand read addresses (A: i*N+k, B: k*N+j)
//   rd_en             operand read strobe
//   a_rdata, b_rdata  operand data, valid one cycle after rd_en
//   res_we            one-cycle result write strobe
//   res_addr          result address i*N+j
//   res_data          C[i][j], sign-extended
//   mm_done           level: all N*N results processed
//   drop_err          sticky: a result completed while wr_en was low
// ---------------------------------------------------------------------------
module mm_mac_engine
    import mm_pkg::*;
#(
    parameter int N    = 3,
    parameter int DW   = 8,
    parameter int AW   = mm_aw(N),
    parameter int ACCW = mm_accw(N, DW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            start_mac,
    input  logic            wr_en,
    output logic [AW-1:0]   a_addr,
    output logic [AW-1:0]   b_addr,
    output logic            rd_en,
    input  logic [DW-1:0]   a_rdata,
    input  logic [DW-1:0]   b_rdata,
    output logic            res_we,
    output logic [AW-1:0]   res_addr,
    output logic [ACCW-1:0] res_data,
    output logic            mm_done,
    output logic            drop_err
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mm_state_e      r_state;
    logic [CW-1:0]  r_i, r_j, r_k;
    logic           r_mm_done;

    // r_vld_pipe[1]: an issue is in flight (data arrives this cycle)
    // r_vld_pipe[2]: the MAC stage retired an issue on the last edge
    logic [STAGES:1] r_vld_pipe;
    logic            r_first1;
    logic            r_last1;
    logic [AW-1:0]   r_tag1;

    logic w_issue;
    logic w_final;

    assign w_issue = (r_state == ST_RUN) && start_mac;
    assign w_final = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);

    assign rd_en   = w_issue;
    assign a_addr  = AW'(idx(int'(r_i), int'(r_k), N));
    assign b_addr  = AW'(idx(int'(r_k), int'(r_j), N));
    assign mm_done = r_mm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_vld_pipe <= '0;
            r_first1   <= 1'b0;
            r_last1    <= 1'b0;
            r_tag1     <= '0;
            r_mm_done  <= 1'b0;
        end else if (load) begin
            // Dropping the valid bits discards any read already in flight.
            r_state    <= ST_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_vld_pipe <= '0;
            r_first1   <= 1'b0;
            r_last1    <= 1'b0;
            r_tag1     <= '0;
            r_mm_done  <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_issue};

            if (w_issue) begin
                r_first1 <= (r_k == '0);
                r_last1  <= (r_k == LAST);
                r_tag1   <= AW'(idx(int'(r_i), int'(r_j), N));
                if (r_k == LAST) begin
                    r_k <= '0;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= (r_i == LAST) ? '0 : r_i + CW'(1);
                    end else begin
                        r_j <= r_j + CW'(1);
                    end
                end else begin
                    r_k <= r_k + CW'(1);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_mac) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_issue && w_final) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Nothing left in flight and the final element retired on
                    // the previous edge: its write strobe is being presented
                    // now, so done rises on the edge that ends that cycle.
                    if (!r_vld_pipe[1] && r_vld_pipe[2]) begin
                        r_state   <= ST_FINISH;
                        r_mm_done <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_mm_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mm_mac_unit #(
        .DW   (DW),
        .AW   (AW),
        .ACCW (ACCW)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (load),
        .i_vld      (r_vld_pipe[1]),
        .i_first    (r_first1),
        .i_last     (r_last1),
        .i_tag      (r_tag1),
        .i_wr_en    (wr_en),
        .i_a        (a_rdata),
        .i_b        (b_rdata),
        .o_res_we   (res_we),
        .o_res_addr (res_addr),
        .o_res_data (res_data),
        .o_drop_err (drop_err)
    );

endmodule

// File: tb/tb_mm_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_mm_mac_engine
// Two engines (N=2 and N=3) share the controller strobes; each has its own
// operand memories. Results are compared against hand-computed tables (N=2)
// and a plain triple-loop matrix product (both sizes).
// ---------------------------------------------------------------------------
module tb_mm_mac_engine;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic load      = 1'b0;
    logic start_mac = 1'b0;
    logic wr_en     = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]  a_addr2, b_addr2, res_addr2;
    logic        rd_en2, res_we2, mm_done2, drop_err2;
    logic [7:0]  a_rdata2 = '0, b_rdata2 = '0;
    logic [16:0] res_data2;

    logic [3:0]  a_addr3, b_addr3, res_addr3;
    logic        rd_en3, res_we3, mm_done3, drop_err3;
    logic [7:0]  a_rdata3 = '0, b_rdata3 = '0;
    logic [17:0] res_data3;

    mm_mac_engine #(.N(2), .DW(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load), .start_mac(start_mac), .wr_en(wr_en),
        .a_addr(a_addr2), .b_addr(b_addr2), .rd_en(rd_en2),
        .a_rdata(a_rdata2), .b_rdata(b_rdata2),
        .res_we(res_we2), .res_addr(res_addr2), .res_data(res_data2),
        .mm_done(mm_done2), .drop_err(drop_err2)
    );

    mm_mac_engine #(.N(3), .DW(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .load(load), .start_mac(start_mac), .wr_en(wr_en),
        .a_addr(a_addr3), .b_addr(b_addr3), .rd_en(rd_en3),
        .a_rdata(a_rdata3), .b_rdata(b_rdata3),
        .res_we(res_we3), .res_addr(res_addr3), .res_data(res_data3),
        .mm_done(mm_done3), .drop_err(drop_err3)
    );

    // Synchronous-read operand memories
    int mA2[9], mB2[9], mA3[9], mB3[9];
    always @(posedge clk) begin
        if (rd_en2) begin
            a_rdata2 <= 8'(mA2[a_addr2]);
            b_rdata2 <= 8'(mB2[b_addr2]);
        end
        if (rd_en3) begin
            a_rdata3 <= 8'(mA3[a_addr3]);
            b_rdata3 <= 8'(mB3[b_addr3]);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write / done monitors
    typedef struct packed { int addr; int data; int cyc; } wr_t;
    wr_t log2[$];
    wr_t log3[$];
    int  done2_cyc = -1;
    int  done3_cyc = -1;

    always @(negedge clk) begin
        if (res_we2) log2.push_back('{int'(res_addr2), int'($signed(res_data2)), cyc});
        if (res_we3) log3.push_back('{int'(res_addr3), int'($signed(res_data3)), cyc});
        if (mm_done2 && done2_cyc < 0) done2_cyc = cyc;
        if (mm_done3 && done3_cyc < 0) done3_cyc = cyc;
    end

    int checks   = 0;
    int failures = 0;
    int s        = 0;   // edge number that samples start_mac=1 in IDLE

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        log2.delete();
        log3.delete();
        done2_cyc = -1;
        done3_cyc = -1;
    endtask

    // Reference: plain matrix product on row-major arrays
    function automatic void model(input int n, input int a[9], input int b[9], output int c[9]);
        for (int x = 0; x < 9; x++) c[x] = 0;
        for (int r = 0; r < n; r++)
            for (int col = 0; col < n; col++) begin
                int sum;
                sum = 0;
                for (int k = 0; k < n; k++) sum += a[r*n + k] * b[k*n + col];
                c[r*n + col] = sum;
            end
    endfunction

    // Writes must appear in row-major order, skipping a deliberately dropped one
    task automatic check_log(input string nm, input wr_t q[$], input int n,
                             input int c[9], input int skip);
        int qi;
        qi = 0;
        for (int x = 0; x < n*n; x++) begin
            if (x != skip) begin
                if (qi < q.size()) begin
                    chk({nm, ".addr"}, q[qi].addr, x);
                    chk({nm, ".data"}, q[qi].data, c[x]);
                end else begin
                    chk({nm, ".missing_write"}, -1, x);
                end
                qi++;
            end
        end
        chk({nm, ".nwrites"}, q.size(), qi);
    endtask

    task automatic rand_mem(input int which);
        for (int x = 0; x < 9; x++) begin
            if (which == 2) begin
                mA2[x] = int'($urandom_range(0, 255)) - 128;
                mB2[x] = int'($urandom_range(0, 255)) - 128;
            end else begin
                mA3[x] = int'($urandom_range(0, 255)) - 128;
                mB3[x] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    // load and start_mac together: load must win, RUN starts one edge later
    task automatic begin_run(input string nm);
        load = 1'b1; start_mac = 1'b1; wr_en = 1'b1;
        tick(1);
        chk({nm, ".load_wins_rd_en"}, int'(rd_en2), 0);
        chk({nm, ".done_cleared"}, int'(mm_done2), 0);
        load = 1'b0;
        clear_mon();
        s = cyc + 1;
    endtask

    task automatic wait_done(input string nm, input int bound);
        int t;
        t = 0;
        while ((done2_cyc < 0 || done3_cyc < 0) && t < bound) begin
            tick(1);
            t++;
        end
        chk({nm, ".done_within_bound"}, int'(done2_cyc >= 0 && done3_cyc >= 0), 1);
        tick(2);
    endtask

    task automatic finish_run(input string nm, input int lat2, input int lat3,
                              input int c2[9], input int skip2, input int drop2);
        int c3[9];
        model(3, mA3, mB3, c3);
        if (lat2 >= 0) chk({nm, ".lat2"}, done2_cyc - s, lat2);
        if (lat3 >= 0) chk({nm, ".lat3"}, done3_cyc - s, lat3);
        check_log({nm, ".n2"}, log2, 2, c2, skip2);
        check_log({nm, ".n3"}, log3, 3, c3, -1);
        chk({nm, ".drop2"}, int'(drop_err2), drop2);
        chk({nm, ".drop3"}, int'(drop_err3), 0);
        chk({nm, ".done2_level"}, int'(mm_done2), 1);
        start_mac = 1'b0;
    endtask

    function automatic int outs_nonzero2();
        return int'(|{rd_en2, res_we2, mm_done2, drop_err2, a_addr2, b_addr2, res_addr2, res_data2});
    endfunction
    function automatic int outs_nonzero3();
        return int'(|{rd_en3, res_we3, mm_done3, drop_err3, a_addr3, b_addr3, res_addr3, res_data3});
    endfunction

    // N=2 table: {A, B, expected C}, all row-major
    typedef struct packed {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][31:0] c;
    } vec_t;
    vec_t vecs[3];

    function automatic vec_t mk(input int a[4], input int b[4], input int c[4]);
        vec_t v;
        for (int x = 0; x < 4; x++) begin
            v.a[x] = 8'(a[x]);
            v.b[x] = 8'(b[x]);
            v.c[x] = 32'(c[x]);
        end
        return v;
    endfunction

    int basic_c[9];
    int c2[9];

    task automatic load_vec(input int v);
        for (int x = 0; x < 9; x++) begin
            mA2[x] = 0; mB2[x] = 0; c2[x] = 0;
        end
        for (int x = 0; x < 4; x++) begin
            mA2[x] = int'($signed(vecs[v].a[x]));
            mB2[x] = int'($signed(vecs[v].b[x]));
            c2[x]  = int'($signed(vecs[v].c[x]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 43, 50});
        vecs[1] = mk('{-128, -128, -128, -128}, '{-128, -128, -128, -128},
                     '{32768, 32768, 32768, 32768});
        vecs[2] = mk('{-1, 2, 3, -4}, '{1, 0, 0, 1}, '{-1, 2, 3, -4});
        for (int x = 0; x < 9; x++) basic_c[x] = (x < 4) ? int'($signed(vecs[0].c[x])) : 0;

        // Reset state
        #3;
        chk("reset.outs2", outs_nonzero2(), 0);
        chk("reset.outs3", outs_nonzero3(), 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven runs, no stalls
        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            rand_mem(3);
            begin_run($sformatf("vec%0d", v));
            wait_done($sformatf("vec%0d", v), 200);
            finish_run($sformatf("vec%0d", v), 10, 29, c2, -1, 0);
        end

        // Stall: start_mac low for 3 cycles after the 3rd issue
        load_vec(0);
        rand_mem(3);
        begin_run("stall");
        tick(4);
        start_mac = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("stall.rd_en2", int'(rd_en2), 0);
            tick(1);
        end
        start_mac = 1'b1;
        wait_done("stall", 200);
        finish_run("stall", 13, 32, basic_c, -1, 0);

        // Abort: load after the 5th issue, then restart
        load_vec(0);
        rand_mem(3);
        begin_run("abort");
        tick(6);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        clear_mon();
        s = cyc + 1;
        chk("abort.done_low", int'(mm_done2), 0);
        chk("abort.we_low", int'(res_we2), 0);
        wait_done("abort", 200);
        finish_run("abort", 10, 29, basic_c, -1, 0);

        // Write gating: wr_en low at the edge that completes addr1
        load_vec(0);
        rand_mem(3);
        begin_run("gate");
        tick(5);
        wr_en = 1'b0;
        tick(1);
        wr_en = 1'b1;
        @(negedge clk);
        chk("gate.drop_now", int'(drop_err2), 1);
        wait_done("gate", 200);
        finish_run("gate", 10, 29, basic_c, 1, 1);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("gate.drop_cleared", int'(drop_err2), 0);

        // Asynchronous reset mid-RUN
        load_vec(0);
        rand_mem(3);
        begin_run("rst");
        tick(4);
        #2;
        rst_n = 1'b0;
        start_mac = 1'b0;
        #1;
        chk("rst.outs2", outs_nonzero2(), 0);
        chk("rst.outs3", outs_nonzero3(), 0);
        clear_mon();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        tick(15);
        chk("rst.no_writes2", log2.size(), 0);
        chk("rst.no_writes3", log3.size(), 0);
        chk("rst.done_low", int'(mm_done2 | mm_done3), 0);

        // Random regression; later passes toggle start_mac randomly
        for (int it = 0; it < 5; it++) begin
            int t;
            rand_mem(2);
            rand_mem(3);
            model(2, mA2, mB2, c2);
            begin_run($sformatf("rnd%0d", it));
            if (it == 0) begin
                wait_done("rnd0", 200);
                finish_run("rnd0", 10, 29, c2, -1, 0);
            end else begin
                t = 0;
                while ((done2_cyc < 0 || done3_cyc < 0) && t < 400) begin
                    start_mac = ($urandom_range(0, 3) != 0);
                    tick(1);
                    t++;
                end
                wait_done($sformatf("rnd%0d", it), 10);
                finish_run($sformatf("rnd%0d", it), -1, -1, c2, -1, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
